// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register-file slave.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } apb_slv_state_t;

    localparam int unsigned APB_WORD_BYTES = 4;

    // Expand one word's byte strobes into a per-bit write mask.
    function automatic logic [APB_WORD_BYTES*8-1:0] strb_mask(
        input logic [APB_WORD_BYTES-1:0] strb
    );
        logic [APB_WORD_BYTES*8-1:0] m;
        for (int unsigned b = 0; b < APB_WORD_BYTES; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/apb_regfile_decode.sv
// Combinational address decode for the APB register file: range/alignment
// hit, register index, and error flag (miss or write to the read-only ID).
module apb_regfile_decode
    import apb_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_A000
) (
    input  logic [ADDR_WIDTH-1:0]       paddr,
    input  logic                        pwrite,
    output logic                        hit,
    output logic [$clog2(NUM_REGS)-1:0] idx,
    output logic                        err
);

    localparam int unsigned           IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(APB_WORD_BYTES * NUM_REGS);

    logic [ADDR_WIDTH-1:0] offset;

    // Offset is only meaningful when paddr >= BASE_ADDR, which hit also requires.
    always_comb begin
        offset = paddr - BASE_ADDR;
        hit    = (paddr >= BASE_ADDR) && (offset < SPAN) && (paddr[1:0] == 2'b00);
        idx    = offset[IDX_W+1:2];
        err    = !hit || (pwrite && (idx == '0));
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB slave with NUM_REGS software registers, programmable wait states,
// byte strobes, error response and a read-only ID register at offset 0.
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           NUM_REGS    = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_A000,
    parameter int unsigned           WAIT_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'h5A5A_0001
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int unsigned IDX_W  = $clog2(NUM_REGS);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned GROUPS = (STRB_W + APB_WORD_BYTES - 1) / APB_WORD_BYTES;
    localparam int unsigned PAD_W  = GROUPS * APB_WORD_BYTES;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    apb_slv_state_t        state;
    logic [3:0]            cnt;
    logic                  access;
    logic                  enter_resp;
    logic                  commit;
    logic                  hit;
    logic [IDX_W-1:0]      idx;
    logic                  err;
    logic [PAD_W-1:0]      strb_pad;
    logic [PAD_W*8-1:0]    mask_pad;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] regs_q  [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] rd_view [NUM_REGS];

    apb_regfile_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_decode (
        .paddr  (paddr),
        .pwrite (pwrite),
        .hit    (hit),
        .idx    (idx),
        .err    (err)
    );

    // Strobes are expanded word by word so the package helper stays fixed-width.
    always_comb begin
        strb_pad = PAD_W'(pstrb);
        mask_pad = '0;
        for (int unsigned g = 0; g < GROUPS; g++) begin
            mask_pad[g*APB_WORD_BYTES*8 +: APB_WORD_BYTES*8] =
                strb_mask(strb_pad[g*APB_WORD_BYTES +: APB_WORD_BYTES]);
        end
        wmask = mask_pad[DATA_WIDTH-1:0];
    end

    // The response is produced on the edge that enters ST_RESP, so pready,
    // pslverr, prdata, the register update and wr_pulse_o all appear together.
    always_comb begin
        access     = psel && penable;
        enter_resp = access && (((state == ST_IDLE) && (WAIT_CYCLES == 0)) ||
                                ((state == ST_WAIT) && (cnt == 4'd0)));
        commit     = enter_resp && pwrite && !err;
    end

    // Register 0 is the constant ID; the rest come from storage.
    always_comb begin
        rd_view[0] = ID_VALUE;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            rd_view[i] = regs_q[i];
        end
    end

    // Flatten register contents for downstream hardware.
    always_comb begin
        regs_o = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_o[i*DATA_WIDTH +: DATA_WIDTH] = rd_view[i];
        end
    end

    // Access FSM with registered response outputs.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            prdata     <= '0;
            pready     <= 1'b0;
            pslverr    <= 1'b0;
            wr_pulse_o <= '0;
        end else begin
            pready     <= 1'b0;
            pslverr    <= 1'b0;
            prdata     <= '0;
            wr_pulse_o <= '0;
            if (enter_resp) begin
                pready     <= 1'b1;
                pslverr    <= err;
                prdata     <= (!pwrite && hit && !err) ? rd_view[idx] : '0;
                wr_pulse_o <= commit ? (NUM_REGS'(1) << idx) : '0;
            end
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        cnt   <= WAIT_LOAD;
                        state <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (!access) begin
                        state <= ST_IDLE;
                    end else if (cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Byte-lane register update on a committed write.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (idx == IDX_W'(i)) begin
                    regs_q[i] <= (regs_q[i] & ~wmask) | (pwdata & wmask);
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Self-checking bench for apb_regfile_slave: one instance with two wait
// states and one with none, checked against a register-array model.
module tb_apb_regfile_slave;

    localparam int unsigned NR   = 8;
    localparam logic [31:0] BASE = 32'h0000_A000;
    localparam logic [31:0] ID   = 32'h5A5A_0001;

    logic         pclk = 1'b0;
    logic         preset = 1'b1;
    logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0]  paddr = '0, pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic         sel = 1'b0;

    logic         psel_a, psel_b;
    logic [31:0]  prdata_a, prdata_b, prdata_m;
    logic         pready_a, pready_b, pready_m;
    logic         pslverr_a, pslverr_b, pslverr_m;
    logic [255:0] regs_a, regs_b, regs_m;
    logic [7:0]   wrp_a, wrp_b, wrp_m;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [2][NR];
    logic [31:0] rd;

    assign psel_a    = psel && !sel;
    assign psel_b    = psel && sel;
    assign prdata_m  = sel ? prdata_b  : prdata_a;
    assign pready_m  = sel ? pready_b  : pready_a;
    assign pslverr_m = sel ? pslverr_b : pslverr_a;
    assign regs_m    = sel ? regs_b    : regs_a;
    assign wrp_m     = sel ? wrp_b     : wrp_a;

    always #5 pclk = ~pclk;

    apb_regfile_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(NR),
        .BASE_ADDR(BASE), .WAIT_CYCLES(2), .ID_VALUE(ID)
    ) dut_a (
        .pclk(pclk), .preset(preset), .psel(psel_a), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a),
        .regs_o(regs_a), .wr_pulse_o(wrp_a)
    );

    apb_regfile_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(NR),
        .BASE_ADDR(BASE), .WAIT_CYCLES(0), .ID_VALUE(ID)
    ) dut_b (
        .pclk(pclk), .preset(preset), .psel(psel_b), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b),
        .regs_o(regs_b), .wr_pulse_o(wrp_b)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mdl[d][0] = ID;
            for (int i = 1; i < NR; i++) mdl[d][i] = '0;
        end
    endtask

    function automatic logic [255:0] model_flat(input logic d);
        logic [255:0] f;
        for (int i = 0; i < NR; i++) f[i*32 +: 32] = mdl[d][i];
        return f;
    endfunction

    // One complete APB transfer; entered and left at #1 after a rising edge.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rdata);
        int unsigned exp_cyc, idx, n;
        logic        hit, e, early;
        logic [31:0] exp_rd;
        logic [7:0]  exp_wp;
        exp_cyc = sel ? 2 : 4;
        hit     = (addr >= BASE) && (addr < BASE + 4*NR) && (addr % 4 == 0);
        idx     = hit ? (addr - BASE) / 4 : 0;
        e       = !hit || (wr && idx == 0);
        exp_rd  = (!wr && !e) ? mdl[sel][idx] : 32'h0;
        exp_wp  = (wr && !e) ? (8'd1 << idx) : 8'h0;

        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
        @(posedge pclk); #1;
        penable = 1'b1;
        n = 1;
        early = 1'b0;
        while (!pready_m && n < 40) begin
            early = early | (|wrp_m);
            @(posedge pclk); #1;
            n++;
        end
        check("ready_cycle", 256'(n), 256'(exp_cyc));
        check("early_pulse", 256'(early), 256'(0));
        check("pslverr", 256'(pslverr_m), 256'(e));
        check("prdata", 256'(prdata_m), 256'(exp_rd));
        check("wr_pulse", 256'(wrp_m), 256'(exp_wp));
        rdata = prdata_m;
        if (wr && !e) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) mdl[sel][idx][b*8 +: 8] = wd[b*8 +: 8];
        end
        check("regs_o", regs_m, model_flat(sel));
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        check("after_resp", 256'({pready_m, wrp_m}), 256'(0));
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;

        // Reset state
        check("rst_pready", 256'(pready_a), 256'(0));
        check("rst_prdata", 256'(prdata_a), 256'(0));
        check("rst_pslverr", 256'(pslverr_a), 256'(0));
        check("rst_wr_pulse", 256'(wrp_a), 256'(0));
        check("rst_regs", regs_a, model_flat(1'b0));

        // ID read, full write, partial-strobe write
        sel = 1'b0;
        xfer(32'hA000, 1'b0, 32'h0, 4'h0, rd);
        check("id_read", 256'(rd), 256'(32'h5A5A_0001));
        xfer(32'hA004, 1'b1, 32'hDEAD_BEEF, 4'hF, rd);
        xfer(32'hA004, 1'b0, 32'h0, 4'h0, rd);
        check("full_write", 256'(rd), 256'(32'hDEAD_BEEF));
        xfer(32'hA004, 1'b1, 32'h1122_3344, 4'b0101, rd);
        xfer(32'hA004, 1'b0, 32'h0, 4'h0, rd);
        check("strobe_write", 256'(rd), 256'(32'hDE22_BE44));

        // Error responses: ID write, out-of-range and misaligned reads
        xfer(32'hA000, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        xfer(32'hA020, 1'b0, 32'h0, 4'h0, rd);
        xfer(32'hA006, 1'b0, 32'h0, 4'h0, rd);
        xfer(32'hA000, 1'b0, 32'h0, 4'h0, rd);
        check("id_unchanged", 256'(rd), 256'(32'h5A5A_0001));

        // Abort a write to register 2 during the wait phase
        begin
            logic seen;
            psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hA008;
            pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
            @(posedge pclk); #1 penable = 1'b1;
            @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                seen = seen | pready_a | (|wrp_a);
                @(posedge pclk); #1;
            end
            check("abort_no_resp", 256'(seen), 256'(0));
            check("abort_regs", regs_a, model_flat(1'b0));
            xfer(32'hA008, 1'b0, 32'h0, 4'h0, rd);
            check("abort_read", 256'(rd), 256'(0));
        end

        // Randomized traffic on both instances
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            if (d == 1) begin
                xfer(32'hA01C, 1'b1, 32'h8765_4321, 4'hF, rd);
                xfer(32'hA01C, 1'b0, 32'h0, 4'h0, rd);
                check("b2b_read", 256'(rd), 256'(32'h8765_4321));
            end
            for (int k = 0; k < 40; k++) begin
                logic [31:0] a;
                if ($urandom_range(0, 3) != 0) a = BASE + 4 * $urandom_range(0, NR);
                else a = BASE - 4 + $urandom_range(0, 40);
                xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), rd);
            end
        end

        // Reset asserted in the access phase of a zero-wait write
        sel = 1'b1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hA00C;
        pwdata = 32'h1234_5678; pstrb = 4'hF;
        @(posedge pclk); #1 penable = 1'b1;
        preset = 1'b1;
        #1;
        model_reset();
        check("midrst_pready", 256'(pready_b), 256'(0));
        check("midrst_prdata", 256'(prdata_b), 256'(0));
        check("midrst_pslverr", 256'(pslverr_b), 256'(0));
        check("midrst_wr_pulse", 256'(wrp_b), 256'(0));
        check("midrst_regs_b", regs_b, model_flat(1'b1));
        check("midrst_regs_a", regs_a, model_flat(1'b0));
        @(posedge pclk); #1;
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        xfer(32'hA00C, 1'b0, 32'h0, 4'h0, rd);
        check("midrst_lost", 256'(rd), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
Parametrised APB slave holding NUM_REGS software registers at BASE_ADDR, replacing the single fixed-address register slave.
- Adds programmable wait states, byte strobes (pstrb), error response (pslverr) and a read-only ID register at offset 0.
- Exports all register contents and per-register write pulses to downstream hardware.
- Sits on the APB bus behind the existing APB master.

Parameters:
- DATA_WIDTH, 32, data bus width; multiple of 8.
- ADDR_WIDTH, 32, address bus width.
- NUM_REGS, 8, number of registers; ≥2, power of two.
- BASE_ADDR, 32'h0000_A000, byte address of register 0; aligned to 4*NUM_REGS.
- WAIT_CYCLES, 2, extra wait cycles before pready; 0..15.
- ID_VALUE, 32'h5A5A_0001, constant value of read-only register 0.

Ports:
- pclk  in  1  bus clock; all logic on rising edge.
- preset  in  1  asynchronous, active-high reset.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte-lane enables.
- prdata  out  DATA_WIDTH  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  error response; valid only with pready.
- regs_o  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse_o  out  NUM_REGS  one-cycle pulse on the cycle a register is updated.

Behaviour:
- One clock (pclk); reset preset is asynchronous, active-high.
- Reset values:
  - state = ST_IDLE; prdata = 0; pready = 0; pslverr = 0; wr_pulse_o = 0.
  - Registers 1..NUM_REGS-1 = 0; register 0 always reads ID_VALUE.
- Address decode (combinational):
  - hit = paddr ≥ BASE_ADDR, paddr < BASE_ADDR + 4*NUM_REGS, and paddr[1:0] == 0.
  - idx = (paddr - BASE_ADDR) >> 2.
  - err = !hit, or (pwrite and idx == 0).
- FSM, states ST_IDLE, ST_WAIT, ST_RESP:
  - ST_IDLE: on psel && penable, load wait counter with WAIT_CYCLES-1; go to ST_WAIT if WAIT_CYCLES > 0, else ST_RESP.
  - ST_WAIT: decrement counter; at 0 go to ST_RESP.
  - ST_RESP: pready = 1 for exactly one cycle, then ST_IDLE.
  - Access phase therefore lasts WAIT_CYCLES+2 cycles including the pready cycle.
- pready, pslverr and prdata are registered; all are asserted and valid only in ST_RESP.
- prdata = 0 in every other cycle, on writes, and on errored reads.
- Write commit:
  - On the ST_RESP clock edge when pwrite and !err, each byte lane b with pstrb[b] = 1 is updated from pwdata; other lanes hold.
  - wr_pulse_o[idx] pulses for that same single cycle, even if pstrb = 0.
- Errored write: no register change, no wr_pulse_o, pslverr = 1.
- Errored read: prdata = 0, pslverr = 1.
- Abort: psel or penable deasserting in ST_WAIT or ST_RESP returns the FSM to ST_IDLE next cycle. No commit, no pready.
- paddr, pwrite, pwdata and pstrb are sampled in the ST_RESP cycle; the master holds them stable per APB.
- Back-to-back transfers: after ST_RESP, a new access is accepted from ST_IDLE. The minimum gap is the master's setup cycle.
- Reset asserted mid-transfer: immediate return to reset values; the pending write is lost.
- regs_o reflects registers directly (no added latency); slice 0 = ID_VALUE.

Decomposition:
- Package apb_pkg holds:
  - typedef apb_slv_state_t {ST_IDLE, ST_WAIT, ST_RESP};
  - localparam APB_WORD_BYTES = 4;
  - function strb_mask(pstrb) expanding strobes to a bit mask.
- Sub-module apb_regfile_decode (combinational): paddr, pwrite in; hit, idx, err out. Parametrised by BASE_ADDR, NUM_REGS, ADDR_WIDTH.

Test Plan:
- Reset, then read 0xA000 -> pready on the 4th access-phase cycle (WAIT_CYCLES=2), prdata = 0x5A5A0001, pslverr = 0.
- Write 0xDEADBEEF to 0xA004 with pstrb = 4'hF, then read 0xA004 -> 0xDEADBEEF; wr_pulse_o[1] high for exactly one cycle.
- Write 0x11223344 to 0xA004 with pstrb = 4'b0101, then read -> 0xDE22BE44.
- Write to 0xA000, read 0xA020 (out of range) and read 0xA006 (misaligned) -> each gives pslverr = 1 with pready; prdata = 0; register 0 unchanged.
- Drop psel during ST_WAIT of a write to 0xA008 -> no pready; register 2 stays 0; next read of 0xA008 returns 0.
- Rebuild with WAIT_CYCLES = 0 and run back-to-back write/read to 0xA01C -> pready on the 2nd access cycle each time; read returns the written data. Assert preset mid-write -> all outputs return to reset values.
